// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU encodings: access-size codes, tracker entry width and the load-data extractor.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B  = 2'b00,
        LSU_SIZE_H  = 2'b01,
        LSU_SIZE_W  = 2'b10,
        LSU_SIZE_WX = 2'b11
    } lsu_size_e;

    // {load, size, usign, addr, rd, misalgn}
    function automatic int lsu_entry_w(input int rd_w);
        return 1 + 2 + 1 + 32 + rd_w + 1;
    endfunction

    function automatic logic [31:0] lsu_load_extract(
        input logic [31:0] rdata,
        input logic [1:0]  lo,
        input lsu_size_e   size,
        input logic        usign
    );
        logic [31:0] sh;
        sh = rdata >> {lo, 3'b000};
        case (size)
            LSU_SIZE_B: return usign ? {24'b0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
            LSU_SIZE_H: return usign ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:    return sh;
        endcase
    endfunction

endpackage

// File: rtl/fifo_simple.sv
// Generic valid/ready FIFO, DP entries, pointers wrap modulo DP; read data is combinational from the head.
// Latency 1 cycle push-to-pop; CUT_READY=1 makes i_rdy depend only on occupancy (no same-cycle pop bypass).
module fifo_simple #(
    parameter int CUT_READY         = 0,
    parameter int ZEROOUT_WHENEMPTY = 1,
    parameter int DP                = 2,
    parameter int DW                = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);

    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = $clog2(DP + 1);

    logic [DW-1:0] mem [DP];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          wr;
    logic          rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (cnt == CW'(DP));
    assign empty = (cnt == '0);
    assign i_rdy = (CUT_READY != 0) ? ~full : (~full | o_rdy);
    assign o_vld = ~empty;
    assign wr    = i_vld & i_rdy;
    assign rd    = o_vld & o_rdy;
    assign o_dat = ((ZEROOUT_WHENEMPTY != 0) && empty) ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr) wptr <= ptr_inc(wptr);
            if (rd) rptr <= ptr_inc(rptr);
            cnt <= cnt + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= i_dat;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: issues aligned lsu_cmd beats, tracks requests in order, retires them as write-back beats.
// Latency 0 cycles req->cmd and rsp->wbck; misaligned entries retire the cycle after push once at head.
// Backpressure: agu_req_rdy drops when the tracker is full (no pop bypass); lsu_rsp_rdy follows wbck_rdy.
// Optional MYRISCV_LSU_MISALGN_EXCP_EN: raise misaligned accesses as exceptions instead of issuing them.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int OUTS_DP = 2,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            agu_req_vld,
    output logic            agu_req_rdy,
    input  logic            agu_req_load,
    input  logic [31:0]     agu_req_addr,
    input  logic [31:0]     agu_req_wdata,
    input  logic [1:0]      agu_req_size,
    input  logic            agu_req_usign,
    input  logic [RD_W-1:0] agu_req_rd,
    output logic            lsu_cmd_vld,
    input  logic            lsu_cmd_rdy,
    output logic            lsu_cmd_read,
    output logic [31:0]     lsu_cmd_addr,
    output logic [31:0]     lsu_cmd_wdata,
    output logic [3:0]      lsu_cmd_wmask,
    input  logic            lsu_rsp_vld,
    output logic            lsu_rsp_rdy,
    input  logic [31:0]     lsu_rsp_rdata,
    input  logic            lsu_rsp_err,
    output logic            wbck_vld,
    input  logic            wbck_rdy,
    output logic [31:0]     wbck_data,
    output logic [RD_W-1:0] wbck_rd,
    output logic            wbck_load,
    output logic            wbck_err,
    output logic            wbck_misalgn,
    output logic [31:0]     wbck_badaddr
);

    localparam int ENT_W = lsu_entry_w(RD_W);

    typedef struct packed {
        logic            load;
        lsu_size_e       size;
        logic            usign;
        logic [31:0]     addr;
        logic [RD_W-1:0] rd;
        logic            misalgn;
    } ent_t;

    lsu_size_e   req_size;
    logic        req_misalgn;
    logic        trk_not_full;
    logic        push;
    logic        pop;
    logic        head_vld;
    ent_t        req_ent;
    ent_t        head;
    logic [3:0]  wmask;
    logic [31:0] wdata_rep;
    logic        bus_done;

    assign req_size = lsu_size_e'(agu_req_size);

`ifdef MYRISCV_LSU_MISALGN_EXCP_EN
    assign req_misalgn = ((req_size == LSU_SIZE_H) & agu_req_addr[0])
                       | (req_size[1] & (agu_req_addr[1:0] != 2'b00));
`else
    assign req_misalgn = 1'b0;
`endif

    assign lsu_cmd_vld = ~rst & agu_req_vld & trk_not_full & ~req_misalgn;
    assign agu_req_rdy = ~rst & trk_not_full & (req_misalgn | lsu_cmd_rdy);
    assign push        = agu_req_vld & agu_req_rdy;

    assign req_ent = '{load:    agu_req_load,
                       size:    req_size,
                       usign:   agu_req_usign,
                       addr:    agu_req_addr,
                       rd:      agu_req_rd,
                       misalgn: req_misalgn};

    // Shifts land in 4 bits, so a half at lane 3 keeps only lane 3 when misaligned issue is allowed.
    always_comb begin
        wmask     = 4'b1111;
        wdata_rep = agu_req_wdata;
        case (req_size)
            LSU_SIZE_B: begin
                wmask     = 4'b0001 << agu_req_addr[1:0];
                wdata_rep = {4{agu_req_wdata[7:0]}};
            end
            LSU_SIZE_H: begin
                wmask     = 4'b0011 << agu_req_addr[1:0];
                wdata_rep = {2{agu_req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (agu_req_load) wmask = 4'b0000;
    end

    assign lsu_cmd_read  = lsu_cmd_vld & agu_req_load;
    assign lsu_cmd_addr  = lsu_cmd_vld ? {agu_req_addr[31:2], 2'b00} : 32'h0;
    assign lsu_cmd_wdata = lsu_cmd_vld ? wdata_rep : 32'h0;
    assign lsu_cmd_wmask = lsu_cmd_vld ? wmask : 4'b0000;

    fifo_simple #(
        .CUT_READY         (1),
        .ZEROOUT_WHENEMPTY (0),
        .DP                (OUTS_DP),
        .DW                (ENT_W)
    ) u_trk (
        .clk   (clk),
        .rst   (rst),
        .i_vld (push),
        .i_rdy (trk_not_full),
        .i_dat (req_ent),
        .o_vld (head_vld),
        .o_rdy (pop),
        .o_dat (head)
    );

    // Misaligned heads retire on their own and never consume a bus response.
    assign wbck_vld    = ~rst & head_vld & (head.misalgn | lsu_rsp_vld);
    assign lsu_rsp_rdy = ~rst & head_vld & ~head.misalgn & wbck_rdy;
    assign pop         = wbck_vld & wbck_rdy;
    assign bus_done    = head_vld & ~head.misalgn & lsu_rsp_vld;

    assign wbck_err     = bus_done & lsu_rsp_err;
    assign wbck_misalgn = head_vld & head.misalgn;
    assign wbck_rd      = head_vld ? head.rd : '0;
    assign wbck_load    = head_vld & head.load;
    assign wbck_data    = (bus_done & head.load & ~lsu_rsp_err)
                        ? lsu_load_extract(lsu_rsp_rdata, head.addr[1:0], head.size, head.usign)
                        : 32'h0;
    assign wbck_badaddr = (wbck_err | wbck_misalgn) ? head.addr : 32'h0;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage directly upstream of the LSU address splitter. It accepts one memory request per handshake from the AGU and drives the splitter's `lsu_cmd_*` channel with a byte-lane-aligned write mask and replicated write data. Requests that cannot go to the bus are raised as exceptions instead. It tracks outstanding requests in order and turns each `lsu_rsp_*` beat into a write-back beat with the selected bytes and sign/zero extension applied.

## Interface
- `OUTS_DP`, 2: outstanding-request tracker depth, ≥1.
- `RD_W`, 5: destination register index width.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `agu_req_vld` / `agu_req_rdy` in/out 1: request handshake.
- `agu_req_load` in 1: 1 = load, 0 = store.
- `agu_req_addr` in 32: byte address.
- `agu_req_wdata` in 32: store data, right-justified.
- `agu_req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `agu_req_usign` in 1: zero-extend the load result.
- `agu_req_rd` in `RD_W`: destination register.
- `lsu_cmd_vld` / `lsu_cmd_rdy` out/in 1: command to the splitter.
- `lsu_cmd_read` out 1, `lsu_cmd_addr` out 32, `lsu_cmd_wdata` out 32, `lsu_cmd_wmask` out 4.
- `lsu_rsp_vld` / `lsu_rsp_rdy` in/out 1: response from the splitter.
- `lsu_rsp_rdata` in 32, `lsu_rsp_err` in 1.
- `wbck_vld` / `wbck_rdy` out/in 1: completion handshake. Exactly one completion per accepted request.
- `wbck_data` out 32, `wbck_rd` out `RD_W`, `wbck_load` out 1.
- `wbck_err` out 1: bus error.
- `wbck_misalgn` out 1: misaligned-access exception.
- `wbck_badaddr` out 32: faulting address.

## Operation
- Misalignment: `misalgn` = (half & addr[0]) | (word & addr[1:0]≠0). Byte accesses are never misaligned.
- Tracker: in-order FIFO of `OUTS_DP` entries holding {load, size, usign, addr, rd, misalgn}.
- `full` blocks acceptance even when a pop happens in the same cycle; there is no bypass.
- Issue: `lsu_cmd_vld` = `agu_req_vld` & ~full & ~misalgn.
- Accept: `agu_req_rdy` = ~full & (misalgn | `lsu_cmd_rdy`). Push on `agu_req_vld` & `agu_req_rdy`.
- Command fields: `lsu_cmd_read` = load; `lsu_cmd_addr` = {addr[31:2], 2'b00}.
- Write mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Loads drive a mask of 0.
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Retire, head is a bus request: `wbck_vld` = `lsu_rsp_vld`; `lsu_rsp_rdy` = `wbck_rdy`. The head pops on `wbck_vld` & `wbck_rdy`.
- Retire, head is misaligned: `wbck_vld` = 1 and `lsu_rsp_rdy` = 0. No bus response is consumed.
- Load data: `rdata` >> (head.addr[1:0]*8), then select the byte/half/word and sign- or zero-extend per `usign`.
- `wbck_data` is 0 for stores, errors and misaligned entries.
- `wbck_err` = `lsu_rsp_err` for bus-retired entries.
- `wbck_badaddr` = head.addr whenever `wbck_err` or `wbck_misalgn` is set, otherwise 0.
- Tracker empty: `lsu_rsp_rdy` = 0 and `wbck_vld` = 0.

## Timing
- Command issue: combinational, 0 cycles from `agu_req_vld`.
- Completion: combinational from `lsu_rsp_vld`. A misaligned entry completes the cycle after it is pushed, once it is at the head.
- Tracker state updates on `clk` rising edge.
- Reset:
  - Tracker empties.
  - While `rst` is high, `agu_req_rdy`, `lsu_cmd_vld`, `lsu_rsp_rdy` and `wbck_vld` are forced to 0.
  - All data outputs read 0 on the first cycle after reset.
  - Reset mid-operation discards all outstanding entries. The downstream splitter is reset by the same `rst`.
- Simultaneous push and pop when not full: both take effect and the count is unchanged.
- Pointers wrap modulo `OUTS_DP`.

## Configuration
- `MYRISCV_LSU_MISALGN_EXCP_EN` defined: behaviour as above. Misaligned requests are never sent to the bus and retire with `wbck_misalgn` = 1.
- `MYRISCV_LSU_MISALGN_EXCP_EN` undefined:
  - `misalgn` is tied to 0 and `wbck_misalgn` to 0.
  - The address is issued word-aligned.
  - The wmask is the shifted value truncated to 4 bits.
  - Load extraction uses addr[1:0] as-is, so results are implementation-defined for misaligned accesses.

## Structure
- Size encodings `LSU_SIZE_B`/`LSU_SIZE_H`/`LSU_SIZE_W` and the tracker entry width go in `mydefines.v`, next to the existing `LSU_SELECT_*` constants.
- The tracker is an instance of the existing `fifo_simple`:
  - CUT_READY=1, ZEROOUT_WHENEMPTY=0.
  - DP=`OUTS_DP`, DW = entry width.
- Alignment, extraction and handshake logic stay inline.

## Test plan
- Store byte: addr 0x8000_0003, wdata 0x0000_00A5 → cmd addr 0x8000_0000, wmask 4'b1000, wdata 0xA5A5_A5A5. The completion has wbck_load=0 and data 0.
- Signed half load: addr 0x2002, rdata 0x8123_4567 → wbck_data 0xFFFF_8123. With usign=1 → 0x0000_8123.
- Misaligned word load at 0x1001 with the macro on → no lsu_cmd_vld; next cycle wbck_misalgn=1, badaddr 0x1001. Macro off → cmd addr 0x1000 issued.
- Back-pressure, OUTS_DP=2: two loads accepted with lsu_rsp_vld=0 → agu_req_rdy=0. Then lsu_rsp_vld=1 and wbck_rdy=1 → first completion pops, and rdy returns to 1 the following cycle.
- Bus error: lsu_rsp_err=1 on a word load at 0x4000_0010 → wbck_err=1, wbck_data 0, badaddr 0x4000_0010.
- Reset asserted with 2 entries outstanding → the cycle after reset has wbck_vld=0, and a new request issues normally.
